// File: rtl/fakeram_driver_pkg.sv
// Shared definitions for the fakeram 512x8 driver slice.
//
// Holds the default RAM geometry, response buffer depth, the request record
// (we, addr, wd) and two small sizing helpers used by the driver and its
// response FIFO.
package fakeram_driver_pkg;

  localparam int BITS_DEF       = 8;
  localparam int ADDR_WIDTH_DEF = 9;
  localparam int RSP_DEPTH_DEF  = 4;

  // One request as offered on the request channel.
  typedef struct packed {
    logic                      we;
    logic [ADDR_WIDTH_DEF-1:0] addr;
    logic [BITS_DEF-1:0]       wd;
  } ram_req_t;

  // Width able to hold the values 0..depth inclusive (occupancy counters).
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Width of a pointer into a depth-entry buffer (at least one bit).
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fakeram_512x8_driver_if.sv
// Request/response bundle of the fakeram 512x8 driver.
//
// The driver exposes these signals as flat ports with identical names, so an
// instance of this interface maps onto the driver 1:1.
//   master : the client issuing requests and consuming read data
//   slave  : the driver side accepting requests and returning read data
// Signals:
//   req_valid_in / req_ready_out        request handshake
//   req_we_in, req_addr_in, req_wd_in   request fields (1 = write)
//   rsp_valid_out / rsp_ready_in        read response handshake
//   rsp_rd_out                          read data
interface fakeram_512x8_driver_if #(
  parameter int BITS       = fakeram_driver_pkg::BITS_DEF,
  parameter int ADDR_WIDTH = fakeram_driver_pkg::ADDR_WIDTH_DEF
);

  logic                  req_valid_in;
  logic                  req_ready_out;
  logic                  req_we_in;
  logic [ADDR_WIDTH-1:0] req_addr_in;
  logic [BITS-1:0]       req_wd_in;
  logic                  rsp_valid_out;
  logic                  rsp_ready_in;
  logic [BITS-1:0]       rsp_rd_out;

  modport master (
    output req_valid_in, req_we_in, req_addr_in, req_wd_in, rsp_ready_in,
    input  req_ready_out, rsp_valid_out, rsp_rd_out
  );

  modport slave (
    input  req_valid_in, req_we_in, req_addr_in, req_wd_in, rsp_ready_in,
    output req_ready_out, rsp_valid_out, rsp_rd_out
  );

endinterface

// File: rtl/fakeram_rsp_fifo.sv
// Read-response buffer for the fakeram driver.
//
// Synchronous FIFO of DEPTH entries. Output data comes straight from the
// storage flops selected by the read pointer, so a word pushed on one edge is
// visible no earlier than the following cycle. Push and pop may coincide at
// any occupancy; the caller guarantees it never pushes into a full buffer.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   push, push_data   write one entry at the end of this cycle
//   pop               consume the head entry (ignored when empty)
//   valid, data       head entry; both forced to zero while reset is high
//   count             current occupancy 0..DEPTH
module fakeram_rsp_fifo
  import fakeram_driver_pkg::*;
#(
  parameter int WIDTH = BITS_DEF,
  parameter int DEPTH = RSP_DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic                       valid,
  output logic [WIDTH-1:0]           data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam int CNT_W = cnt_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             do_pop;

  // Pointers wrap modulo DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign do_pop = pop & (cnt != '0);

  // NOTE: the data array has no reset; clearing the pointers and count is
  // enough to make stale contents unreachable, and it keeps the array a plain
  // register file.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // NOTE: all state updates use non-blocking assignments so every flop sees
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push)   wr_ptr <= bump(wr_ptr);
      if (do_pop) rd_ptr <= bump(rd_ptr);
      unique case ({push, do_pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign valid = !reset && (cnt != '0);
  assign data  = valid ? mem[rd_ptr] : '0;
  assign count = cnt;

endmodule

// File: rtl/fakeram_512x8_driver.sv
// Request/response driver in front of a fakeram 512x8 macro.
//
// Requests are passed straight through to the RAM on the cycle they are
// accepted. The RAM returns read data one cycle later; it is captured into a
// response FIFO and handed to the consumer in request order, at the earliest
// two cycles after the request was accepted. Writes produce no response.
// Reads are only accepted while the FIFO has room for every read still in
// flight, so read data is never dropped; writes are always accepted.
// Ports:
//   clk, reset                               clock, sync active-high reset
//   req_valid_in/req_ready_out               request handshake
//   req_we_in, req_addr_in, req_wd_in        request fields (1 = write)
//   rsp_valid_out/rsp_ready_in, rsp_rd_out   read response channel
//   ram_ce_out, ram_we_out, ram_addr_out,
//   ram_wd_out, ram_rd_in                    RAM macro pins
module fakeram_512x8_driver
  import fakeram_driver_pkg::*;
#(
  parameter int BITS       = BITS_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int RSP_DEPTH  = RSP_DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid_in,
  output logic                  req_ready_out,
  input  logic                  req_we_in,
  input  logic [ADDR_WIDTH-1:0] req_addr_in,
  input  logic [BITS-1:0]       req_wd_in,
  output logic                  rsp_valid_out,
  input  logic                  rsp_ready_in,
  output logic [BITS-1:0]       rsp_rd_out,
  output logic                  ram_ce_out,
  output logic                  ram_we_out,
  output logic [ADDR_WIDTH-1:0] ram_addr_out,
  output logic [BITS-1:0]       ram_wd_out,
  input  logic [BITS-1:0]       ram_rd_in
);

  localparam int CNT_W = cnt_width(RSP_DEPTH);

  logic             accept;
  logic             pending_rd;
  logic [CNT_W-1:0] occupancy;
  logic [CNT_W:0]   credit_used;

  // Slots already spoken for: buffered words plus the read whose data the
  // RAM presents this cycle. A same-cycle pop is deliberately not credited,
  // which keeps ready off the response-ready path.
  assign credit_used   = {1'b0, occupancy} + (CNT_W + 1)'(pending_rd);
  assign req_ready_out = !reset &&
                         (req_we_in || (credit_used < (CNT_W + 1)'(RSP_DEPTH)));
  assign accept        = req_valid_in & req_ready_out;

  // RAM pins are zero whenever nothing is accepted, never floating.
  // NOTE: every output gets its default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    ram_ce_out   = 1'b0;
    ram_we_out   = 1'b0;
    ram_addr_out = '0;
    ram_wd_out   = '0;
    if (accept) begin
      ram_ce_out   = 1'b1;
      ram_we_out   = req_we_in;
      ram_addr_out = req_addr_in;
      ram_wd_out   = req_wd_in;
    end
  end

  // Marks the cycle in which the RAM presents data for last cycle's read.
  always_ff @(posedge clk) begin
    if (reset) pending_rd <= 1'b0;
    else       pending_rd <= accept & ~req_we_in;
  end

  // ram_rd_in is only sampled when pending_rd is set; otherwise it is X.
  fakeram_rsp_fifo #(
    .WIDTH (BITS),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (pending_rd),
    .push_data (ram_rd_in),
    .pop       (rsp_valid_out & rsp_ready_in),
    .valid     (rsp_valid_out),
    .data      (rsp_rd_out),
    .count     (occupancy)
  );

endmodule

// File: tb/tb_fakeram_512x8_driver.sv
// Self-checking bench for fakeram_512x8_driver with a behavioural 512x8
// merge-write RAM. Expected behaviour comes from a queue of outstanding
// reads (value captured from a reference memory at accept time), which gives
// the credit limit, the response order and the two-cycle response latency.
module tb_fakeram_512x8_driver
  import fakeram_driver_pkg::*;
;

  localparam int RSP_DEPTH = RSP_DEPTH_DEF;

  logic       clk = 1'b0;
  logic       rst;
  logic       ram_ce, ram_we;
  logic [8:0] ram_addr;
  logic [7:0] ram_wd, ram_rd;
  logic       ram_clear;

  fakeram_512x8_driver_if #(.BITS(8), .ADDR_WIDTH(9)) bus ();

  fakeram_512x8_driver dut (
    .clk           (clk),
    .reset         (rst),
    .req_valid_in  (bus.req_valid_in),
    .req_ready_out (bus.req_ready_out),
    .req_we_in     (bus.req_we_in),
    .req_addr_in   (bus.req_addr_in),
    .req_wd_in     (bus.req_wd_in),
    .rsp_valid_out (bus.rsp_valid_out),
    .rsp_ready_in  (bus.rsp_ready_in),
    .rsp_rd_out    (bus.rsp_rd_out),
    .ram_ce_out    (ram_ce),
    .ram_we_out    (ram_we),
    .ram_addr_out  (ram_addr),
    .ram_wd_out    (ram_wd),
    .ram_rd_in     (ram_rd)
  );

  always #5 clk = ~clk;

  // RAM macro: registered read, OR-merge write, X on rd when not reading.
  logic [7:0] ram_mem [512];
  always @(posedge clk) begin
    if (ram_clear) begin
      for (int i = 0; i < 512; i++) ram_mem[i] <= 8'h00;
      ram_rd <= 'x;
    end else if (ram_ce) begin
      if (ram_we) begin
        ram_mem[ram_addr] <= ram_mem[ram_addr] | ram_wd;
        ram_rd <= 'x;
      end else begin
        ram_rd <= ram_mem[ram_addr];
      end
    end else begin
      ram_rd <= 'x;
    end
  end

  // Reference model state.
  typedef struct {
    logic [7:0] data;
    int         cyc;
  } exp_rsp_t;

  logic [7:0] ref_mem [512];
  exp_rsp_t   exp_q [$];
  int         cyc;
  int         n_tests = 0;
  int         n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Continuous pin hygiene: RAM address/data never X, ce low when idle.
  always @(negedge clk) begin
    if (!rst || cyc > 0) begin
      check("ram_addr_known", 32'($isunknown(ram_addr)), 32'd0);
      check("ram_wd_known", 32'($isunknown(ram_wd)), 32'd0);
      if ((bus.req_valid_in & bus.req_ready_out) !== 1'b1)
        check("ram_ce_idle", 32'(ram_ce), 32'd0);
    end
  end

  // One clock cycle: drive, compare against the model at mid-cycle, advance
  // the model with what the coming edge will do.
  task automatic step(input logic r, input logic v, input ram_req_t q,
                      input logic rr, output logic o_ready,
                      output logic o_valid, output logic [7:0] o_rd);
    logic       e_ready, e_acc, e_valid;
    logic [7:0] e_rd;
    rst              = r;
    bus.req_valid_in = v;
    bus.req_we_in    = q.we;
    bus.req_addr_in  = q.addr;
    bus.req_wd_in    = q.wd;
    bus.rsp_ready_in = rr;
    @(negedge clk);
    e_ready = !r && (q.we || exp_q.size() < RSP_DEPTH);
    e_acc   = v && e_ready;
    e_valid = !r && exp_q.size() > 0 && cyc >= exp_q[0].cyc + 2;
    e_rd    = e_valid ? exp_q[0].data : 8'h00;
    check("req_ready", 32'(bus.req_ready_out), 32'(e_ready));
    check("ram_ce", 32'(ram_ce), 32'(e_acc));
    check("ram_we", 32'(ram_we), 32'(e_acc && q.we));
    check("ram_addr", 32'(ram_addr), e_acc ? 32'(q.addr) : 32'd0);
    check("ram_wd", 32'(ram_wd), e_acc ? 32'(q.wd) : 32'd0);
    check("rsp_valid", 32'(bus.rsp_valid_out), 32'(e_valid));
    check("rsp_rd", 32'(bus.rsp_rd_out), 32'(e_rd));
    o_ready = bus.req_ready_out;
    o_valid = bus.rsp_valid_out;
    o_rd    = bus.rsp_rd_out;
    if (r) begin
      exp_q.delete();
    end else begin
      if (e_valid && rr) void'(exp_q.pop_front());
      if (e_acc) begin
        if (q.we) ref_mem[q.addr] = ref_mem[q.addr] | q.wd;
        else      exp_q.push_back('{ref_mem[q.addr], cyc});
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  logic       o_r, o_v;
  logic [7:0] o_d;

  task automatic rd(input logic [8:0] a, input logic rr);
    step(1'b0, 1'b1, '{we: 1'b0, addr: a, wd: 8'h00}, rr, o_r, o_v, o_d);
  endtask

  task automatic wr(input logic [8:0] a, input logic [7:0] d, input logic rr);
    step(1'b0, 1'b1, '{we: 1'b1, addr: a, wd: d}, rr, o_r, o_v, o_d);
  endtask

  task automatic idle(input logic rr);
    step(1'b0, 1'b0, '{we: 1'b0, addr: 9'h0, wd: 8'h00}, rr, o_r, o_v, o_d);
  endtask

  typedef struct {
    logic       rst;
    logic       v;
    ram_req_t   req;
    logic       exp_ready;
    logic       exp_valid;
    logic [7:0] exp_rd;
  } vec_t;

  vec_t vecs [12];

  initial begin
    logic [7:0] got [$];
    logic [7:0] want [8];
    int         n_acc, n_rsp;
    ram_req_t   rq;

    // Directed vectors: reset, write/read 0x005, merge-write 0x1FF.
    vecs[0]  = '{1'b1, 1'b1, '{1'b1, 9'h005, 8'hA5}, 1'b0, 1'b0, 8'h00};
    vecs[1]  = '{1'b1, 1'b1, '{1'b1, 9'h005, 8'hA5}, 1'b0, 1'b0, 8'h00};
    vecs[2]  = '{1'b0, 1'b1, '{1'b1, 9'h005, 8'hA5}, 1'b1, 1'b0, 8'h00};
    vecs[3]  = '{1'b0, 1'b1, '{1'b0, 9'h005, 8'h00}, 1'b1, 1'b0, 8'h00};
    vecs[4]  = '{1'b0, 1'b0, '{1'b0, 9'h000, 8'h00}, 1'b1, 1'b0, 8'h00};
    vecs[5]  = '{1'b0, 1'b0, '{1'b0, 9'h000, 8'h00}, 1'b1, 1'b1, 8'hA5};
    vecs[6]  = '{1'b0, 1'b1, '{1'b1, 9'h1FF, 8'h0F}, 1'b1, 1'b0, 8'h00};
    vecs[7]  = '{1'b0, 1'b1, '{1'b1, 9'h1FF, 8'hF0}, 1'b1, 1'b0, 8'h00};
    vecs[8]  = '{1'b0, 1'b1, '{1'b0, 9'h1FF, 8'h00}, 1'b1, 1'b0, 8'h00};
    vecs[9]  = '{1'b0, 1'b0, '{1'b0, 9'h000, 8'h00}, 1'b1, 1'b0, 8'h00};
    vecs[10] = '{1'b0, 1'b0, '{1'b0, 9'h000, 8'h00}, 1'b1, 1'b1, 8'hFF};
    vecs[11] = '{1'b0, 1'b0, '{1'b0, 9'h000, 8'h00}, 1'b1, 1'b0, 8'h00};

    cyc              = 0;
    rst              = 1'b1;
    ram_clear        = 1'b1;
    bus.req_valid_in = 1'b0;
    bus.req_we_in    = 1'b0;
    bus.req_addr_in  = '0;
    bus.req_wd_in    = '0;
    bus.rsp_ready_in = 1'b1;
    for (int i = 0; i < 512; i++) ref_mem[i] = 8'h00;
    @(posedge clk);
    #1;
    ram_clear = 1'b0;

    for (int i = 0; i < 12; i++) begin
      step(vecs[i].rst, vecs[i].v, vecs[i].req, 1'b1, o_r, o_v, o_d);
      check($sformatf("vec%0d_ready", i), 32'(o_r), 32'(vecs[i].exp_ready));
      check($sformatf("vec%0d_valid", i), 32'(o_v), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d_rd", i), 32'(o_d), 32'(vecs[i].exp_rd));
    end

    // Back-to-back reads of 0..7 with the consumer always ready.
    for (int i = 0; i < 8; i++) wr(9'(i), 8'(i * 37 + 1), 1'b1);
    for (int i = 0; i < 8; i++) want[i] = ref_mem[i];
    got.delete();
    for (int i = 0; i < 8; i++) begin
      rd(9'(i), 1'b1);
      check("b2b_ready", 32'(o_r), 32'd1);
      if (o_v) got.push_back(o_d);
    end
    for (int i = 0; i < 3; i++) begin
      idle(1'b1);
      if (o_v) got.push_back(o_d);
    end
    check("b2b_count", 32'(got.size()), 32'd8);
    for (int i = 0; i < 8 && i < got.size(); i++)
      check($sformatf("b2b_data%0d", i), 32'(got[i]), 32'(want[i]));

    // Stalled consumer: credit runs out after RSP_DEPTH reads.
    n_acc = 0;
    for (int i = 0; i < 6; i++) begin
      rd(9'(i), 1'b0);
      if (o_r) n_acc++;
    end
    check("stall_accepted", 32'(n_acc), 32'(RSP_DEPTH));
    check("stall_ready_low", 32'(o_r), 32'd0);
    wr(9'h100, 8'h3C, 1'b0);
    check("stall_write_ready", 32'(o_r), 32'd1);
    n_rsp = 0;
    for (int i = 0; i < 6; i++) begin
      idle(1'b1);
      if (o_v) n_rsp++;
    end
    check("stall_drained", 32'(n_rsp), 32'(RSP_DEPTH));

    // Reset one cycle after a read accept discards the read.
    idle(1'b1);
    rd(9'h003, 1'b1);
    check("rst_read_accept", 32'(o_r), 32'd1);
    step(1'b1, 1'b0, '{we: 1'b0, addr: 9'h0, wd: 8'h00}, 1'b1, o_r, o_v, o_d);
    check("rst_occupancy", 32'(dut.occupancy), 32'd0);
    check("rst_pending", 32'(dut.pending_rd), 32'd0);
    n_rsp = 0;
    for (int i = 0; i < 4; i++) begin
      idle(1'b1);
      if (o_v) n_rsp++;
    end
    check("rst_no_rsp", 32'(n_rsp), 32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      rq.we   = 1'($urandom_range(0, 1));
      rq.addr = ($urandom_range(0, 3) == 0) ? 9'($urandom) : 9'($urandom_range(0, 15));
      rq.wd   = 8'($urandom);
      step(($urandom_range(0, 59) == 0), 1'($urandom_range(0, 1)), rq,
           ($urandom_range(0, 9) < 7), o_r, o_v, o_d);
    end
    for (int i = 0; i < 8; i++) idle(1'b1);
    check("final_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
